// File: rtl/uart_pkg.sv
// Shared types and constants for the UART RX parity checker.
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_EVEN  = 2'b00,
    PAR_ODD   = 2'b01,
    PAR_MARK  = 2'b10,
    PAR_SPACE = 2'b11
  } par_mode_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    DATA = 2'b01,
    PAR  = 2'b10
  } chk_state_t;

  // Shortest data field a frame may carry; shorter requests are clamped up.
  localparam int DATA_LEN_MIN = 5;

endpackage

// File: rtl/uart_sat_cnt.sv
// Saturating up-counter with a clear that wins over increment.
module uart_sat_cnt #(
  parameter int W = 8
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);

  localparam logic [W-1:0] CNT_MAX = '1;

  // clr+inc lands on 1 so the event that coincides with the clear is not lost.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)
      cnt <= '0;
    else if (clr)
      cnt <= inc ? W'(1) : '0;
    else if (inc && cnt != CNT_MAX)
      cnt <= cnt + W'(1);
  end

endmodule

// File: rtl/uart_par_chk_gen.sv
// Bit-serial RX parity checker: 5..DATA_W data bits, even/odd/mark/space
// parity, one-cycle done strobe and a saturating parity-error counter.
module uart_par_chk_gen
  import uart_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int LEN_W     = 4,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 frame_start,
  input  logic                 par_en,
  input  logic [1:0]           par_mode,
  input  logic [LEN_W-1:0]     data_len,
  input  logic                 sampled_bit,
  input  logic                 data_bit_vld,
  input  logic                 par_bit_vld,
  input  logic                 err_clr,
  output logic                 par_done,
  output logic                 par_err,
  output logic                 busy,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  chk_state_t       state;
  par_mode_t        f_mode;
  logic             f_par_en;
  logic [LEN_W-1:0] f_len;
  logic [LEN_W-1:0] bit_cnt;
  logic [LEN_W-1:0] bit_cnt_nxt;
  logic [LEN_W-1:0] len_clamped;
  logic             acc;
  logic             exp_par;
  logic             err_inc;

  // Clamp the requested data length into the supported window.
  always_comb begin
    len_clamped = data_len;
    if (data_len < LEN_W'(DATA_LEN_MIN))
      len_clamped = LEN_W'(DATA_LEN_MIN);
    else if (data_len > LEN_W'(DATA_W))
      len_clamped = LEN_W'(DATA_W);
  end

  // Parity bit the frame should carry, given the data accumulated so far.
  always_comb begin
    case (f_mode)
      PAR_EVEN: exp_par = acc;
      PAR_ODD:  exp_par = ~acc;
      PAR_MARK: exp_par = 1'b1;
      default:  exp_par = 1'b0;
    endcase
  end

  assign bit_cnt_nxt = bit_cnt + LEN_W'(1);
  // Error verdict is counted in the same cycle par_err is registered.
  assign err_inc = (state == PAR) && par_bit_vld && !frame_start &&
                   (sampled_bit != exp_par);
  assign busy    = (state != IDLE);

  // Frame FSM: frame_start aborts/opens a frame and overrides any strobe.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state    <= IDLE;
      f_mode   <= PAR_EVEN;
      f_par_en <= 1'b0;
      f_len    <= LEN_W'(DATA_LEN_MIN);
      acc      <= 1'b0;
      bit_cnt  <= '0;
      par_done <= 1'b0;
      par_err  <= 1'b0;
    end else begin
      par_done <= 1'b0;
      if (frame_start) begin
        f_mode   <= par_mode_t'(par_mode);
        f_par_en <= par_en;
        f_len    <= len_clamped;
        acc      <= 1'b0;
        bit_cnt  <= '0;
        par_err  <= 1'b0;
        state    <= DATA;
      end else begin
        case (state)
          DATA: if (data_bit_vld) begin
            acc     <= acc ^ sampled_bit;
            bit_cnt <= bit_cnt_nxt;
            if (bit_cnt_nxt == f_len) begin
              if (f_par_en) begin
                state <= PAR;
              end else begin
                state    <= IDLE;
                par_done <= 1'b1;
                par_err  <= 1'b0;
              end
            end
          end
          PAR: if (par_bit_vld) begin
            par_err  <= (sampled_bit != exp_par);
            par_done <= 1'b1;
            state    <= IDLE;
          end
          default: ;
        endcase
      end
    end
  end

  uart_sat_cnt #(.W(ERR_CNT_W)) u_err_cnt (
    .CLK (CLK),
    .RST (RST),
    .inc (err_inc),
    .clr (err_clr),
    .cnt (err_cnt)
  );

endmodule

// File: tb/tb_uart_par_chk_gen.sv
// Directed bench for uart_par_chk_gen; a second instance with a 2-bit
// error counter shares the inputs for the saturation checks.
module tb_uart_par_chk_gen;

  logic       CLK = 1'b0;
  logic       RST;
  logic       frame_start, par_en, sampled_bit, data_bit_vld, par_bit_vld, err_clr;
  logic [1:0] par_mode;
  logic [3:0] data_len;

  logic       par_done, par_err, busy;
  logic [7:0] err_cnt;
  logic       par_done2, par_err2, busy2;
  logic [1:0] err_cnt2;

  int total = 0;
  int bad   = 0;

  always #5 CLK = ~CLK;

  uart_par_chk_gen #(.DATA_W(8), .LEN_W(4), .ERR_CNT_W(8)) dut (
    .CLK(CLK), .RST(RST), .frame_start(frame_start), .par_en(par_en),
    .par_mode(par_mode), .data_len(data_len), .sampled_bit(sampled_bit),
    .data_bit_vld(data_bit_vld), .par_bit_vld(par_bit_vld), .err_clr(err_clr),
    .par_done(par_done), .par_err(par_err), .busy(busy), .err_cnt(err_cnt)
  );

  uart_par_chk_gen #(.DATA_W(8), .LEN_W(4), .ERR_CNT_W(2)) dut2 (
    .CLK(CLK), .RST(RST), .frame_start(frame_start), .par_en(par_en),
    .par_mode(par_mode), .data_len(data_len), .sampled_bit(sampled_bit),
    .data_bit_vld(data_bit_vld), .par_bit_vld(par_bit_vld), .err_clr(err_clr),
    .par_done(par_done2), .par_err(par_err2), .busy(busy2), .err_cnt(err_cnt2)
  );

  // One clock, then settle 1 time unit past the edge.
  task automatic tick();
    @(posedge CLK); #1;
  endtask

  task automatic start(input logic pe, input logic [1:0] md, input logic [3:0] ln);
    frame_start = 1'b1; par_en = pe; par_mode = md; data_len = ln;
    tick();
    frame_start = 1'b0;
    // Scramble frame inputs: the latched copies must be unaffected.
    par_en = ~pe; par_mode = ~md; data_len = 4'd2;
  endtask

  task automatic send_bit(input logic b);
    data_bit_vld = 1'b1; sampled_bit = b;
    tick();
    data_bit_vld = 1'b0;
  endtask

  task automatic send_bits(input logic [7:0] d, input int n);
    for (int i = 0; i < n; i++) send_bit(d[i]);
  endtask

  task automatic send_par(input logic b);
    par_bit_vld = 1'b1; sampled_bit = b;
    tick();
    par_bit_vld = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b0;
    #12;
    total++;
    if ({par_done, par_err, busy, err_cnt} !== 11'd0) begin
      bad++; $display("FAIL reset: got done=%b err=%b busy=%b cnt=%0d want all 0",
                      par_done, par_err, busy, err_cnt);
    end
    RST = 1'b1;
    tick();
  endtask

  task automatic test_even();
    start(1'b1, 2'b00, 4'd8);
    send_bits(8'h5A, 8);
    total++;
    if (busy !== 1'b1 || par_done !== 1'b0) begin
      bad++; $display("FAIL even_in_par: busy=%b done=%b want 1 0", busy, par_done);
    end
    send_par(1'b0);
    total++;
    if (par_done !== 1'b1 || par_err !== 1'b0 || err_cnt !== 8'd0 || busy !== 1'b0) begin
      bad++; $display("FAIL even_verdict: done=%b err=%b cnt=%0d busy=%b want 1 0 0 0",
                      par_done, par_err, err_cnt, busy);
    end
    tick();
    total++;
    if (par_done !== 1'b0) begin
      bad++; $display("FAIL even_done_pulse: done=%b want 0", par_done);
    end
  endtask

  task automatic test_odd();
    start(1'b1, 2'b01, 4'd7);
    send_bits(8'h13, 7);
    send_par(1'b1);
    total++;
    if (par_done !== 1'b1 || par_err !== 1'b1 || err_cnt !== 8'd1) begin
      bad++; $display("FAIL odd_bad: done=%b err=%b cnt=%0d want 1 1 1",
                      par_done, par_err, err_cnt);
    end
    tick();
    total++;
    if (par_err !== 1'b1 || par_done !== 1'b0) begin
      bad++; $display("FAIL odd_err_hold: err=%b done=%b want 1 0", par_err, par_done);
    end
    start(1'b1, 2'b01, 4'd7);
    total++;
    if (par_err !== 1'b0) begin
      bad++; $display("FAIL odd_err_clr_on_start: err=%b want 0", par_err);
    end
    send_bits(8'h13, 7);
    send_par(1'b0);
    total++;
    if (par_done !== 1'b1 || par_err !== 1'b0 || err_cnt !== 8'd1) begin
      bad++; $display("FAIL odd_good: done=%b err=%b cnt=%0d want 1 0 1",
                      par_done, par_err, err_cnt);
    end
  endtask

  task automatic test_mark_space();
    start(1'b1, 2'b10, 4'd5);
    send_bits(8'h16, 5);
    send_par(1'b0);
    total++;
    if (par_done !== 1'b1 || par_err !== 1'b1 || err_cnt !== 8'd2) begin
      bad++; $display("FAIL mark: done=%b err=%b cnt=%0d want 1 1 2",
                      par_done, par_err, err_cnt);
    end
    start(1'b1, 2'b11, 4'd5);
    send_bits(8'h16, 5);
    send_par(1'b0);
    total++;
    if (par_done !== 1'b1 || par_err !== 1'b0 || err_cnt !== 8'd2) begin
      bad++; $display("FAIL space: done=%b err=%b cnt=%0d want 1 0 2",
                      par_done, par_err, err_cnt);
    end
  endtask

  task automatic test_no_parity();
    start(1'b0, 2'b00, 4'd6);
    send_bits(8'h01, 5);
    total++;
    if (par_done !== 1'b0 || busy !== 1'b1) begin
      bad++; $display("FAIL nopar_early: done=%b busy=%b want 0 1", par_done, busy);
    end
    send_bit(1'b0);
    total++;
    if (par_done !== 1'b1 || par_err !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL nopar_done: done=%b err=%b busy=%b want 1 0 0",
                      par_done, par_err, busy);
    end
    send_par(1'b1);
    total++;
    if (par_done !== 1'b0 || par_err !== 1'b0 || err_cnt !== 8'd2 || busy !== 1'b0) begin
      bad++; $display("FAIL nopar_ignore_par: done=%b err=%b cnt=%0d busy=%b want 0 0 2 0",
                      par_done, par_err, err_cnt, busy);
    end
  endtask

  task automatic test_abort_clamp();
    start(1'b1, 2'b00, 4'd8);
    send_bits(8'h07, 3);
    // Restart with a data strobe in the same cycle; that strobe must be dropped.
    data_bit_vld = 1'b1; sampled_bit = 1'b1;
    start(1'b1, 2'b00, 4'd8);
    data_bit_vld = 1'b0;
    total++;
    if (par_done !== 1'b0 || busy !== 1'b1) begin
      bad++; $display("FAIL abort: done=%b busy=%b want 0 1", par_done, busy);
    end
    send_bits(8'h03, 8);
    send_par(1'b0);
    total++;
    if (par_done !== 1'b1 || par_err !== 1'b0 || err_cnt !== 8'd2) begin
      bad++; $display("FAIL abort_new_frame: done=%b err=%b cnt=%0d want 1 0 2",
                      par_done, par_err, err_cnt);
    end
    // data_len 3 clamps to 5
    start(1'b0, 2'b00, 4'd3);
    send_bits(8'h00, 4);
    total++;
    if (par_done !== 1'b0) begin
      bad++; $display("FAIL clamp_lo_early: done=%b want 0", par_done);
    end
    send_bit(1'b0);
    total++;
    if (par_done !== 1'b1) begin
      bad++; $display("FAIL clamp_lo: done=%b want 1", par_done);
    end
    // data_len 12 clamps to 8
    start(1'b0, 2'b00, 4'd12);
    send_bits(8'h00, 7);
    total++;
    if (par_done !== 1'b0) begin
      bad++; $display("FAIL clamp_hi_early: done=%b want 0", par_done);
    end
    send_bit(1'b0);
    total++;
    if (par_done !== 1'b1) begin
      bad++; $display("FAIL clamp_hi: done=%b want 1", par_done);
    end
  endtask

  task automatic test_sat_rst();
    logic [1:0] want;
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    total++;
    if (err_cnt2 !== 2'd0 || err_cnt !== 8'd0) begin
      bad++; $display("FAIL sat_clr: cnt2=%0d cnt=%0d want 0 0", err_cnt2, err_cnt);
    end
    for (int k = 1; k <= 4; k++) begin
      start(1'b1, 2'b10, 4'd5);
      send_bits(8'h00, 5);
      send_par(1'b0);
      want = (k > 3) ? 2'd3 : 2'(k);
      total++;
      if (err_cnt2 !== want || par_err2 !== 1'b1) begin
        bad++; $display("FAIL sat_err%0d: cnt2=%0d err=%b want %0d 1", k, err_cnt2, par_err2, want);
      end
    end
    start(1'b1, 2'b10, 4'd5);
    send_bits(8'h00, 5);
    err_clr = 1'b1;
    send_par(1'b0);
    err_clr = 1'b0;
    total++;
    if (err_cnt2 !== 2'd1 || err_cnt !== 8'd1 || par_err2 !== 1'b1) begin
      bad++; $display("FAIL clr_with_err: cnt2=%0d cnt=%0d err=%b want 1 1 1",
                      err_cnt2, err_cnt, par_err2);
    end
    start(1'b1, 2'b00, 4'd5);
    send_bits(8'h00, 5);
    #2 RST = 1'b0;
    #1;
    total++;
    if ({par_done2, par_err2, busy2, err_cnt2} !== 5'd0 ||
        {par_done, par_err, busy, err_cnt} !== 11'd0) begin
      bad++; $display("FAIL rst_mid_par: busy2=%b cnt2=%0d busy=%b cnt=%0d want all 0",
                      busy2, err_cnt2, busy, err_cnt);
    end
    tick();
    RST = 1'b1;
    tick();
  endtask

  initial begin
    frame_start = 0; par_en = 0; par_mode = 0; data_len = 0;
    sampled_bit = 0; data_bit_vld = 0; par_bit_vld = 0; err_clr = 0;
    test_reset();
    test_even();
    test_odd();
    test_mark_space();
    test_no_parity();
    test_abort_clamp();
    test_sat_rst();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
